// File: rtl/spi_responder_pkg.sv
// Shared constants and types for the SPI register-file responder.
package spi_resp_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    // Interrupt flag register (write-1-to-clear when the irq feature is built in)
    localparam logic [ADDR_W-1:0] IRQ_FLAG_ADDR = 5'h19;
    localparam logic [ADDR_W-1:0] IRQ_EN_ADDR   = 5'h1A;

    // Position of the direction bit in the command byte (1 = write)
    localparam int DIR_BIT = 1;

endpackage

// File: rtl/spi_responder_if.sv
// SPI pins, fabric update port and write-commit / irq outputs of spi_responder.
interface spi_responder_if;
    import spi_resp_pkg::*;

    logic              spi_sclk;
    logic              spi_ss_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [7:0]        status_in;
    logic              upd_en;
    logic [ADDR_W-1:0] upd_addr;
    logic [7:0]        upd_data;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              irq;

    // View from the responder block
    modport slave (
        input  spi_sclk, spi_ss_n, spi_mosi, status_in, upd_en, upd_addr, upd_data,
        output spi_miso, spi_miso_oe, wr_strobe, wr_addr, wr_data, irq
    );

    // View from the SPI master / fabric side
    modport master (
        output spi_sclk, spi_ss_n, spi_mosi, status_in, upd_en, upd_addr, upd_data,
        input  spi_miso, spi_miso_oe, wr_strobe, wr_addr, wr_data, irq
    );

endinterface

// File: rtl/spi_responder_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for an asynchronous pin with
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_q;

    assign w_q = r_sync[SYNC_STAGES-1];

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= w_q;
        end
    end

    assign o_rise = w_q & ~r_prev;
    assign o_fall = ~w_q & r_prev;

endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 slave exposing a 32 x 8 register file.
// Command byte = {addr[4:0], x, dir, x}; following bytes read or write the
// same register. Optional feature macro: SPI_RESP_IRQ_EN (irq output and
// write-1-to-clear flag register at 0x19).
module spi_responder
    import spi_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    spi_responder_if.slave  bus
);

    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_ss_rise;
    logic                   w_ss_fall;
    logic                   w_mosi;
    logic [7:0]             w_byte;
    logic                   w_spi_we;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    state_t                 r_state;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx_sr;
    logic [7:0]             r_tx_sr;
    logic                   r_miso;
    logic                   r_oe;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_dir;
    logic                   r_wr_strobe;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [7:0]             r_wr_data;
    logic [7:0]             r_regs [NUM_REGS];

    // SCLK idles low in mode 0; SS_n idles high so reset never looks like a select
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_d     (bus.spi_sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_d     (bus.spi_ss_n),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    // MOSI needs only the level, aligned with the SCLK synchronizer
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_mosi_sync <= '0;
        else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_byte = {r_rx_sr, w_mosi};

    // Data-byte write commit on the 8th rise; a closing SS_n edge wins
    assign w_spi_we = (r_state == DATA) && r_dir && w_sclk_rise &&
                      (r_bit_cnt == 3'd7) && !w_ss_rise;

    // Protocol FSM: bit counting, command decode, MISO shifting, commit strobe
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_addr      <= '0;
            r_dir       <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_ss_rise) begin
                // Deselect drops any partial byte
                r_state   <= IDLE;
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
                r_oe      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_ss_fall) begin
                            r_state   <= CMD;
                            r_bit_cnt <= 3'd0;
                            r_oe      <= 1'b1;
                            r_miso    <= bus.status_in[7];
                            r_tx_sr   <= {bus.status_in[6:0], 1'b0};
                        end
                    end
                    CMD, DATA: begin
                        if (w_sclk_rise) begin
                            r_rx_sr   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_state == CMD) begin
                                    r_addr  <= w_byte[7:3];
                                    r_dir   <= w_byte[DIR_BIT];
                                    r_state <= DATA;
                                    if (!w_byte[DIR_BIT]) r_tx_sr <= r_regs[w_byte[7:3]];
                                end else if (r_dir) begin
                                    r_wr_strobe <= 1'b1;
                                    r_wr_addr   <= r_addr;
                                    r_wr_data   <= w_byte;
                                end else begin
                                    r_tx_sr <= r_regs[r_addr];
                                end
                            end
                        end else if (w_sclk_fall) begin
                            // Next bit goes out on the fall so it is stable at the master's rise
                            r_miso  <= r_tx_sr[7];
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Register file: an SPI commit has priority over a same-cycle fabric update
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_spi_we) begin
`ifdef SPI_RESP_IRQ_EN
            if (r_addr == IRQ_FLAG_ADDR) r_regs[r_addr] <= r_regs[r_addr] & ~w_byte;
            else                         r_regs[r_addr] <= w_byte;
`else
            r_regs[r_addr] <= w_byte;
`endif
        end else if (bus.upd_en) begin
            r_regs[bus.upd_addr] <= bus.upd_data;
        end
    end

`ifdef SPI_RESP_IRQ_EN
    logic r_irq;

    // Interrupt = any pending flag that is also enabled
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_irq <= 1'b0;
        else          r_irq <= |(r_regs[IRQ_FLAG_ADDR] & r_regs[IRQ_EN_ADDR]);
    end

    assign bus.irq = r_irq;
`else
    assign bus.irq = 1'b0;
`endif

    assign bus.spi_miso    = r_miso;
    assign bus.spi_miso_oe = r_oe;
    assign bus.wr_strobe   = r_wr_strobe;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: bit-banged SPI master with 8-clock
// SCLK phases, hand-computed expectations, immediate assertions.
module tb_spi_responder;

    localparam int SYNC = 2;

    logic Clk = 1'b0;
    logic Reset_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_stb = 0;
    logic [4:0] l_addr = '0;
    logic [7:0] l_data = '0;

    spi_responder_if bus();

    spi_responder #(.SYNC_STAGES(SYNC)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Record every cycle wr_strobe is high and the data it carried
    always @(negedge Clk) begin
        if (bus.wr_strobe === 1'b1) begin
            n_stb  <= n_stb + 1;
            l_addr <= bus.wr_addr;
            l_data <= bus.wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift nbits of tx MSB first; rx collects MISO sampled at each rise.
    // coll drives a fabric update in the exact cycle the 8th rise commits.
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit coll,
                        output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = tx[7-i];
            repeat (8) @(negedge Clk);
            rx = {rx[6:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            if (coll && i == 7) begin
                repeat (SYNC) @(negedge Clk);
                chk("strobe_early", {31'd0, bus.wr_strobe}, 32'd0);
                bus.upd_en = 1'b1;
                @(negedge Clk);
                bus.upd_en = 1'b0;
                chk("strobe_latency", {31'd0, bus.wr_strobe}, 32'd1);
                repeat (8 - SYNC - 1) @(negedge Clk);
            end else begin
                repeat (8) @(negedge Clk);
            end
            bus.spi_sclk = 1'b0;
        end
        repeat (8) @(negedge Clk);
    endtask

    task automatic spi_write(input logic [4:0] addr, input logic [7:0] data);
        logic [7:0] d;
        bus.spi_ss_n = 1'b0;
        repeat (8) @(negedge Clk);
        xfer({addr, 3'b010}, 8, 1'b0, d);
        xfer(data, 8, 1'b0, d);
        bus.spi_ss_n = 1'b1;
        repeat (8) @(negedge Clk);
    endtask

    task automatic spi_read(input logic [4:0] addr, output logic [7:0] data);
        logic [7:0] d;
        bus.spi_ss_n = 1'b0;
        repeat (8) @(negedge Clk);
        xfer({addr, 3'b000}, 8, 1'b0, d);
        xfer(8'h00, 8, 1'b0, data);
        bus.spi_ss_n = 1'b1;
        repeat (8) @(negedge Clk);
    endtask

    task automatic upd(input logic [4:0] addr, input logic [7:0] data);
        @(negedge Clk);
        bus.upd_addr = addr;
        bus.upd_data = data;
        bus.upd_en   = 1'b1;
        @(negedge Clk);
        bus.upd_en   = 1'b0;
    endtask

    initial begin
        logic [7:0] rx;
        int         s0;

        Reset_n       = 1'b0;
        bus.spi_sclk  = 1'b0;
        bus.spi_ss_n  = 1'b1;
        bus.spi_mosi  = 1'b0;
        bus.status_in = 8'hA5;
        bus.upd_en    = 1'b0;
        bus.upd_addr  = '0;
        bus.upd_data  = '0;
        repeat (4) @(negedge Clk);

        // Reset state
        chk("rst_miso",   {31'd0, bus.spi_miso},    32'd0);
        chk("rst_oe",     {31'd0, bus.spi_miso_oe}, 32'd0);
        chk("rst_strobe", {31'd0, bus.wr_strobe},   32'd0);
        chk("rst_waddr",  {27'd0, bus.wr_addr},     32'd0);
        chk("rst_wdata",  {24'd0, bus.wr_data},     32'd0);
        chk("rst_irq",    {31'd0, bus.irq},         32'd0);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);

        // Single write to reg 5
        s0 = n_stb;
        spi_write(5'd5, 8'h5C);
        chk("wr_count", n_stb - s0, 32'd1);
        chk("wr_addr",  {27'd0, l_addr}, 32'd5);
        chk("wr_data",  {24'd0, l_data}, 32'h5C);

        // Read back: status during the command byte, then the register
        bus.spi_ss_n = 1'b0;
        repeat (8) @(negedge Clk);
        chk("oe_selected", {31'd0, bus.spi_miso_oe}, 32'd1);
        xfer(8'h28, 8, 1'b0, rx);
        chk("rd_status", {24'd0, rx}, 32'hA5);
        xfer(8'h00, 8, 1'b0, rx);
        chk("rd_data", {24'd0, rx}, 32'h5C);
        bus.spi_ss_n = 1'b1;
        repeat (8) @(negedge Clk);
        chk("oe_idle",   {31'd0, bus.spi_miso_oe}, 32'd0);
        chk("miso_idle", {31'd0, bus.spi_miso},    32'd0);

        // Burst write: address does not increment
        s0 = n_stb;
        bus.spi_ss_n = 1'b0;
        repeat (8) @(negedge Clk);
        xfer(8'h2A, 8, 1'b0, rx);
        xfer(8'h11, 8, 1'b0, rx);
        xfer(8'h22, 8, 1'b0, rx);
        xfer(8'h33, 8, 1'b0, rx);
        bus.spi_ss_n = 1'b1;
        repeat (8) @(negedge Clk);
        chk("burst_count", n_stb - s0, 32'd3);
        chk("burst_addr",  {27'd0, l_addr}, 32'd5);
        chk("burst_data",  {24'd0, l_data}, 32'h33);
        spi_read(5'd5, rx);
        chk("burst_rd", {24'd0, rx}, 32'h33);

        // Abort after 5 bits of a data byte
        s0 = n_stb;
        bus.spi_ss_n = 1'b0;
        repeat (8) @(negedge Clk);
        xfer(8'h2A, 8, 1'b0, rx);
        xfer(8'hFF, 5, 1'b0, rx);
        bus.spi_ss_n = 1'b1;
        repeat (8) @(negedge Clk);
        chk("abort_count", n_stb - s0, 32'd0);
        spi_read(5'd5, rx);
        chk("abort_rd", {24'd0, rx}, 32'h33);

        // Reset asserted mid-byte, with SCLK high
        bus.spi_ss_n = 1'b0;
        repeat (8) @(negedge Clk);
        xfer(8'h2A, 8, 1'b0, rx);
        xfer(8'hFF, 3, 1'b0, rx);
        bus.spi_mosi = 1'b1;
        bus.spi_sclk = 1'b1;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        chk("mid_rst_miso",  {31'd0, bus.spi_miso},    32'd0);
        chk("mid_rst_oe",    {31'd0, bus.spi_miso_oe}, 32'd0);
        chk("mid_rst_waddr", {27'd0, bus.wr_addr},     32'd0);
        chk("mid_rst_wdata", {24'd0, bus.wr_data},     32'd0);
        bus.spi_sclk = 1'b0;
        bus.spi_ss_n = 1'b1;
        repeat (4) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (8) @(negedge Clk);
        spi_read(5'd5, rx);
        chk("mid_rst_rd", {24'd0, rx}, 32'h00);

        // Collision: SPI commit of 0x44 and fabric 0x77 in the same cycle
        bus.spi_ss_n = 1'b0;
        repeat (8) @(negedge Clk);
        xfer(8'h2A, 8, 1'b0, rx);
        bus.upd_addr = 5'd5;
        bus.upd_data = 8'h77;
        xfer(8'h44, 8, 1'b1, rx);
        bus.spi_ss_n = 1'b1;
        repeat (8) @(negedge Clk);
        chk("coll_wdata", {24'd0, l_data}, 32'h44);
        spi_read(5'd5, rx);
        chk("coll_rd", {24'd0, rx}, 32'h44);

        // Fabric update path alone
        upd(5'd3, 8'h9C);
        spi_read(5'd3, rx);
        chk("upd_rd", {24'd0, rx}, 32'h9C);

        // Interrupt flag / enable behaviour
        upd(5'h19, 8'h01);
        upd(5'h1A, 8'h01);
        repeat (3) @(negedge Clk);
`ifdef SPI_RESP_IRQ_EN
        chk("irq_set", {31'd0, bus.irq}, 32'd1);
`else
        chk("irq_set", {31'd0, bus.irq}, 32'd0);
`endif
        spi_write(5'h19, 8'h01);
        repeat (3) @(negedge Clk);
        chk("irq_clr", {31'd0, bus.irq}, 32'd0);
        spi_read(5'h19, rx);
`ifdef SPI_RESP_IRQ_EN
        chk("flag_rd", {24'd0, rx}, 32'h00);
`else
        chk("flag_rd", {24'd0, rx}, 32'h01);
`endif
        spi_read(5'h1A, rx);
        chk("en_rd", {24'd0, rx}, 32'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
